div_sequencer: RTL and testbench

Multicycle integer divide unit for the EX stage. It serves the DIV and DIVU operations.
- EX holds a start request and is stalled until `ready_o` is asserted.
- The sequencer captures the operands, runs 32 restoring shift-subtract steps, applies the signed correction, and returns {remainder, quotient}.
- EX writes that result to HI/LO.
- An annul input lets an exception or flush abandon an in-flight divide.

---
 rtl/div_sequencer_if.sv | 22 ++
 rtl/div_sequencer.sv | 160 ++++++++++++++++
 tb/tb_div_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Handshake and data bundle between the EX stage and the multicycle divider.
interface div_sequencer_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_sequencer.sv
// Multicycle restoring divider for DIV/DIVU; returns {remainder, quotient}
// after DATA_W shift-subtract steps with sign correction for signed ops.
module div_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic           clk,
  input  logic           rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [DATA_W-1:0]     dvd_q,    dvd_d;     // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]     dvs_q,    dvs_d;
  logic [DATA_W-1:0]     rem_q,    rem_d;
  logic                  sgn_q,    sgn_d;
  logic                  dvd_neg_q, dvd_neg_d;
  logic                  dvs_neg_q, dvs_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q,  ready_d;

  logic                  op1_neg_c;
  logic                  op2_neg_c;
  logic [DATA_W-1:0]     op1_abs_c;
  logic [DATA_W-1:0]     op2_abs_c;
  logic [DATA_W:0]       rem_shift_c;
  logic [DATA_W-1:0]     rem_sub_c;
  logic                  step_ge_c;
  logic [DATA_W-1:0]     rem_step_c;
  logic [DATA_W-1:0]     quot_step_c;
  logic [DATA_W-1:0]     quot_fix_c;
  logic [DATA_W-1:0]     rem_fix_c;
  logic                  last_step_c;

  // Operand magnitudes for capture; unsigned ops pass straight through.
  always_comb begin
    op1_neg_c = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    op2_neg_c = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    op1_abs_c = op1_neg_c ? (DATA_W'(0) - bus.opdata1_i) : bus.opdata1_i;
    op2_abs_c = op2_neg_c ? (DATA_W'(0) - bus.opdata2_i) : bus.opdata2_i;
  end

  // One restoring step; the extra top bit keeps the compare exact for large divisors.
  always_comb begin
    rem_shift_c = {rem_q, dvd_q[DATA_W-1]};
    step_ge_c   = (rem_shift_c >= {1'b0, dvs_q});
    rem_sub_c   = rem_shift_c[DATA_W-1:0] - dvs_q;
    rem_step_c  = step_ge_c ? rem_sub_c : rem_shift_c[DATA_W-1:0];
    quot_step_c = {dvd_q[DATA_W-2:0], step_ge_c};
    quot_fix_c  = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? (DATA_W'(0) - quot_step_c) : quot_step_c;
    rem_fix_c   = (sgn_q && dvd_neg_q) ? (DATA_W'(0) - rem_step_c) : rem_step_c;
    last_step_c = (cnt_q == CNT_W'(DATA_W - 1));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    sgn_d     = sgn_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    if (bus.annul_i) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_d  = 1'b0;
          result_d = '0;
          if (bus.start_i) begin
            if (bus.opdata2_i == '0) begin
              state_d = DIVZERO;
            end else begin
              state_d   = BUSY;
              cnt_d     = '0;
              rem_d     = '0;
              dvd_d     = op1_abs_c;
              dvs_d     = op2_abs_c;
              sgn_d     = bus.signed_div_i;
              dvd_neg_d = op1_neg_c;
              dvs_neg_d = op2_neg_c;
            end
          end
        end
        DIVZERO: begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = '0;
        end
        BUSY: begin
          dvd_d = quot_step_c;
          rem_d = rem_step_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step_c) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {rem_fix_c, quot_fix_c};
          end
        end
        DONE: begin
          // EX must drop start to release the result before the next divide.
          if (!bus.start_i) begin
            state_d  = IDLE;
            ready_d  = 1'b0;
            result_d = '0;
          end
        end
        default: begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      sgn_q     <= sgn_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: latency, signed/unsigned results,
// divide-by-zero, annul, async reset and DONE hold behaviour.
module tb_div_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_sequencer_if #(.DATA_W(32)) bus ();

  div_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one divide, measure latency, check hold in DONE, then release.
  task automatic run_div(input logic sdiv, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input int exp_lat, input bit toggle,
                         input string name);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.signed_div_i = sdiv;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o === 1'b1) begin
        lat = n;
        break;
      end
      if (toggle) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~bus.signed_div_i;
      end
    end
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
    end
    total++;
    if (bus.result_o !== exp_res) begin
      bad++;
      $display("FAIL %s result: got %h, expected %h", name, bus.result_o, exp_res);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp_res) begin
        bad++;
        $display("FAIL %s hold%0d: ready=%b result=%h, expected ready=1 result=%h",
                 name, k, bus.ready_o, bus.result_o, exp_res);
      end
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      bad++;
      $display("FAIL %s release: ready=%b result=%h, expected ready=0 result=0",
               name, bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      bad++;
      $display("FAIL reset: ready=%b result=%h, expected ready=0 result=0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divu();
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0, "divu_100_7");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 1'b0, "divu_max_1");
    run_div(1'b0, 32'd0, 32'd5, 64'h0, 33, 1'b0, "divu_zero_dividend");
  endtask

  task automatic test_div_signed();
    run_div(1'b1, 32'hFFFF_FFF8, 32'd3, {32'hFFFF_FFFE, 32'hFFFF_FFFE}, 33, 1'b0, "div_m8_3");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 1'b0, "div_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1'b0, "div_min_m1");
  endtask

  task automatic test_divzero();
    run_div(1'b1, 32'd5, 32'd0, 64'h0, 2, 1'b0, "div_by_zero");
    run_div(1'b0, 32'd5, 32'd0, 64'h0, 2, 1'b0, "divu_by_zero");
  endtask

  task automatic test_annul();
    bit stayed_low;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      bad++;
      $display("FAIL annul_edge: ready=%b result=%h, expected ready=0 result=0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    stayed_low  = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0) stayed_low = 1'b0;
    end
    total++;
    if (stayed_low !== 1'b1) begin
      bad++;
      $display("FAIL annul_quiet: ready went high after annul, expected it to stay 0");
    end
    run_div(1'b0, 32'd9, 32'd2, {32'd1, 32'd4}, 33, 1'b0, "divu_9_2_after_annul");
  endtask

  task automatic test_async_reset();
    bit stayed_low;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      bad++;
      $display("FAIL rst_busy: ready=%b result=%h, expected ready=0 result=0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    stayed_low = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0) stayed_low = 1'b0;
    end
    total++;
    if (stayed_low !== 1'b1) begin
      bad++;
      $display("FAIL rst_busy_discard: aborted divide still raised ready, expected ready=0");
    end

    // Reset while a result is held in DONE must clear it between edges.
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (33) @(posedge clk);
    #2;
    total++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL rst_done_pre: ready=%b result=%h, expected ready=1 result=%h",
               bus.ready_o, bus.result_o, {32'd2, 32'd14});
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      bad++;
      $display("FAIL rst_done: ready=%b result=%h, expected ready=0 result=0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_operand_toggle();
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1, "toggle_divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF8, 32'd3, {32'hFFFF_FFFE, 32'hFFFF_FFFE}, 33, 1'b1, "toggle_div_m8_3");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_divu();
    test_div_signed();
    test_divzero();
    test_annul();
    test_async_reset();
    test_operand_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
